// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128 key scheduler: one round-key expansion per clock into an 11-entry
// register file, with a registered read port for the round datapath.
module aes_key_schedule_seq #(
    parameter int unsigned KEY_W = 128,
    parameter int unsigned NR    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [3:0]       rk_addr,
    output logic [KEY_W-1:0] rk_data,
    output logic             keys_ready,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0] rk_q [0:NR];
    logic             rk_we;
    logic [3:0]       rk_widx;
    logic [KEY_W-1:0] rk_wdata;
    logic [KEY_W-1:0] next_key;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (a^254, maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] b;
        t = gf_mul(gf_mul(a, a), a);          // a^3
        t = gf_mul(gf_mul(t, t), a);          // a^7
        t = gf_mul(gf_mul(t, t), a);          // a^15
        t = gf_mul(gf_mul(t, t), a);          // a^31
        t = gf_mul(gf_mul(t, t), a);          // a^63
        t = gf_mul(gf_mul(t, t), a);          // a^127
        b = gf_mul(t, t);                     // a^254
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Single-round expansion; word 0 sits in the top 32 bits of the key.
    function automatic logic [127:0] generate_key(input logic [3:0] round,
                                                  input logic [127:0] inp_key);
        logic [31:0] w0, w1, w2, w3, t;
        w3 = inp_key[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(round), 24'h000000};
        w0 = inp_key[127:96] ^ t;
        w1 = inp_key[95:64] ^ w0;
        w2 = inp_key[63:32] ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // The one expansion instance, always fed by the entry cnt points at.
    always_comb begin
        next_key = generate_key(cnt_q, rk_q[cnt_q]);
    end

    // Next-state, register-file write and status outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rk_we      = 1'b0;
        rk_widx    = 4'd0;
        rk_wdata   = next_key;
        key_ready  = 1'b0;
        keys_ready = 1'b0;
        busy       = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                key_ready  = 1'b1;
                keys_ready = (state_q == StDone);
                if (key_valid) begin
                    rk_we    = 1'b1;
                    rk_widx  = 4'd0;
                    rk_wdata = key_in;
                    cnt_d    = 4'd0;
                    state_d  = StExpand;
                end
            end
            StExpand: begin
                busy    = 1'b1;
                rk_we   = 1'b1;
                rk_widx = cnt_q + 4'd1;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'(NR - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Round-key register file; cleared on reset so nothing from a partial expansion survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(NR); i++) rk_q[i] <= '0;
        end else begin
            for (int i = 0; i <= int'(NR); i++) begin
                if (rk_we && rk_widx == 4'(i)) rk_q[i] <= rk_wdata;
            end
        end
    end

    // Registered read port; out-of-range indices read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_data <= '0;
        end else if (rk_addr <= 4'(NR)) begin
            rk_data <= rk_q[rk_addr];
        end else begin
            rk_data <= '0;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using FIPS-197 and all-zero key vectors.
module tb_aes_key_schedule_seq;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         keys_ready;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] FipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FipsRk1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FipsRk2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZeroRk1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZeroRk2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] ZeroRk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_schedule_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data),
        .keys_ready(keys_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
        @(negedge clk);
        rk_addr = a;
        @(posedge clk);
        #1;
        d = rk_data;
    endtask

    // Status vector is {keys_ready, key_ready, busy}.
    task automatic load_key(input logic [127:0] k, input bit hold_junk, input string tag);
        @(negedge clk);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_accept_status"}, {keys_ready, key_ready, busy}, 3'b001);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (hold_junk && i < 10) begin
                key_in    = ~k;
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("%s_status_c%0d", tag, i), {keys_ready, key_ready, busy},
                  (i == 10) ? 3'b110 : 3'b001);
        end
    endtask

    logic [127:0] d;

    initial begin
        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rk_addr   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_status", {keys_ready, key_ready, busy}, 3'b010);
        check("reset_rk_data", rk_data, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS key while a junk key is held valid throughout the expansion.
        load_key(FipsKey, 1'b1, "fips");
        read_rk(4'd0, d);  check("fips_rk0", d, FipsKey);
        read_rk(4'd1, d);  check("fips_rk1", d, FipsRk1);
        read_rk(4'd2, d);  check("fips_rk2", d, FipsRk2);
        read_rk(4'd10, d); check("fips_rk10", d, FipsRk10);
        read_rk(4'd11, d); check("fips_addr11", d, '0);
        read_rk(4'd15, d); check("fips_addr15", d, '0);

        // One-cycle read latency: old data persists until the next edge.
        read_rk(4'd10, d);
        @(negedge clk);
        rk_addr = 4'd1;
        #1;
        check("latency_hold", rk_data, FipsRk10);
        @(posedge clk);
        #1;
        check("latency_update", rk_data, FipsRk1);

        // Re-key from DONE with the all-zero key.
        load_key(128'h0, 1'b0, "zero");
        read_rk(4'd0, d);  check("zero_rk0", d, '0);
        read_rk(4'd1, d);  check("zero_rk1", d, ZeroRk1);
        read_rk(4'd2, d);  check("zero_rk2", d, ZeroRk2);
        read_rk(4'd10, d); check("zero_rk10", d, ZeroRk10);

        // Reset in the middle of an expansion.
        @(negedge clk);
        rk_addr   = 4'd0;
        key_in    = FipsKey;
        key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midexp_busy", {keys_ready, key_ready, busy}, 3'b001);
        check("midexp_rk_data", rk_data, FipsKey);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_status", {keys_ready, key_ready, busy}, 3'b010);
        check("rst_rk_data", rk_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            read_rk(4'(a), d);
            check($sformatf("post_rst_rk%0d", a), d, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
